// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_pkg
//  Description : Shared definitions for the RS-232 transmitter: frame
//                geometry, default bit period and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs232_pkg;

  // 8N1 frame: start + 8 data + stop
  localparam int FRAME_BITS            = 10;
  localparam int DATA_BITS             = 8;
  localparam int CLKS_PER_BIT_DEFAULT  = 5208;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/rs232_tx_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_tx_baud_gen
//  Description : Bit-period timer. Counts 0..CLKS_PER_BIT-1 while enabled
//                and pulses bit_end for one cycle on the last count.
//  Ports       : clk     - system clock
//                rst     - synchronous active-high reset
//                enable  - count while high, counter held at 0 while low
//                bit_end - one-cycle pulse marking the last cycle of a bit
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_tx_baud_gen #(
  parameter int CLKS_PER_BIT = rs232_pkg::CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_end
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_count <= '0;
    end else if (r_count == CNT_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign bit_end = enable && (r_count == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/rs232_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_transmitter
//  Description : 8N1 serial transmitter with a one-byte holding register in
//                front of the shift register, so a second byte can be queued
//                while a frame is on the line and frames run back to back.
//  Ports       : clk      - system clock (rising edge)
//                rst      - synchronous active-high reset
//                tx_data  - byte to send, captured on accept
//                tx_valid - send request
//                tx_ready - holding register empty (accept = valid & ready)
//                txd      - registered serial output, idle high
//                busy     - frame on the line or byte held
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_transmitter
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e  r_state;
  tx_state_e  w_state_next;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic [7:0] r_shift;
  logic [7:0] w_shift_next;
  logic [2:0] r_bit_idx;
  logic [2:0] w_bit_idx_next;
  logic       r_txd;
  logic       w_txd_next;
  logic       r_ready_en;
  logic       w_load;
  logic       w_accept;
  logic       w_bit_end;

  rs232_tx_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .enable  (r_state != IDLE),
    .bit_end (w_bit_end)
  );

  // r_ready_en keeps tx_ready low until the first edge after reset release.
  assign tx_ready = r_ready_en && !r_hold_full && !rst;
  assign busy     = ((r_state != IDLE) || r_hold_full) && !rst;
  assign txd      = r_txd;
  assign w_accept = tx_valid && tx_ready;

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_load         = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_state_next = START;
          w_load       = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_next   = {1'b0, r_shift[7:1]};
          // 3-bit index wraps 7 -> 0 on the way out of DATA
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == LAST_BIT) begin
            w_state_next = STOP;
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_hold_full) begin
            w_state_next = START;
            w_load       = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (w_load) begin
      w_shift_next = r_hold;
    end
    // txd is registered from the next state so the line changes on the same
    // edge as the state, giving one clock from accept to start bit.
    case (w_state_next)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = w_shift_next[0];
      default: w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_txd       <= 1'b1;
      r_ready_en  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_idx  <= w_bit_idx_next;
      r_txd      <= w_txd_next;
      r_ready_en <= 1'b1;
      // Transfer empties the holding register first; an accept in the same
      // cycle refills it.
      if (w_load) begin
        r_hold_full <= 1'b0;
      end
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs232_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs232_transmitter
//  Description : Self-checking bench for rs232_transmitter. Three instances
//                with different bit periods; sent bytes are queued as
//                expected frames and compared sample by sample on txd.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_transmitter;
  import rs232_pkg::*;

  localparam int NDUT = 3;
  localparam int CPB0 = CLKS_PER_BIT_DEFAULT;
  localparam int CPB1 = 4;
  localparam int CPB2 = 24;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      tx_data [NDUT];
  logic [NDUT-1:0] tx_valid;
  wire  [NDUT-1:0] tx_ready;
  wire  [NDUT-1:0] txd;
  wire  [NDUT-1:0] busy;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rs232_transmitter #(.CLKS_PER_BIT(CPB0)) u_dut_slow (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .txd(txd[0]), .busy(busy[0]));

  rs232_transmitter #(.CLKS_PER_BIT(CPB1)) u_dut_fast (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .txd(txd[1]), .busy(busy[1]));

  rs232_transmitter #(.CLKS_PER_BIT(CPB2)) u_dut_mid (
    .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .txd(txd[2]), .busy(busy[2]));

  function automatic int cpb(input int idx);
    if (idx == 0) return CPB0;
    if (idx == 1) return CPB1;
    return CPB2;
  endfunction

  // Called just after a rising edge. Holds tx_valid until the byte is taken,
  // then pushes it onto the expected-frame queue.
  task automatic drive_byte(input int idx, input logic [7:0] b, input bit keep_valid,
                            output int acc_cyc);
    bit   ok;
    logic rdy;
    ok          = 1'b0;
    rdy         = 1'bx;
    acc_cyc     = -1;
    tx_data[idx]  = b;
    tx_valid[idx] = 1'b1;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      rdy = tx_ready[idx];
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        ok      = 1'b1;
        acc_cyc = cyc;
      end
    end
    if (!keep_valid) tx_valid[idx] = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_dut%0d: byte %02h never accepted, tx_ready=%b, need 1", idx, b, rdy);
    end else begin
      exp_q.push_back(b);
    end
  endtask

  // Captures one full frame from txd (optionally waiting for a start bit)
  // and checks it against the oldest expected byte.
  task automatic recv_check(input int idx, input bit wait_start, input string name,
                            output int waited);
    int         clks;
    int         nsmp;
    int         bad;
    logic       smp [];
    logic [9:0] fr;
    logic [7:0] exp_b;
    logic [7:0] got;
    clks   = cpb(idx);
    nsmp   = FRAME_BITS * clks;
    smp    = new[nsmp];
    waited = 0;
    @(negedge clk);
    if (wait_start) begin
      while (txd[idx] !== 1'b0 && waited < 40 * clks) begin
        waited++;
        @(negedge clk);
      end
    end
    for (int j = 0; j < nsmp; j++) begin
      if (j > 0) @(negedge clk);
      smp[j] = txd[idx];
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_queue: frame captured with no byte expected, need an expected byte", name);
      return;
    end
    exp_b = exp_q.pop_front();
    fr    = {1'b1, exp_b, 1'b0};
    bad   = 0;
    got   = '0;
    for (int j = 0; j < nsmp; j++) begin
      if (smp[j] !== fr[j / clks]) bad++;
      if ((j % clks) == (clks / 2) && (j / clks) >= 1 && (j / clks) <= 8)
        got[(j / clks) - 1] = smp[j];
    end
    checks++;
    if (got !== exp_b) begin
      failures++;
      $display("FAIL %s_data: got %02h, need %02h", name, got, exp_b);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_timing: %0d of %0d samples off the 8N1 waveform, need 0", name, bad, nsmp);
    end
  endtask

  // Line must stay idle and not busy; resynchronises to just after an edge.
  task automatic check_idle(input int idx, input int ncyc, input string name);
    int bad;
    bad = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (txd[idx] !== 1'b1 || busy[idx] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_idle: %0d non-idle cycles, need 0", name, bad);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_valid = '0;
    for (int i = 0; i < NDUT; i++) tx_data[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (txd !== 3'b111) begin failures++; $display("FAIL rst_txd: got %b, need 111", txd); end
    checks++;
    if (tx_ready !== 3'b000) begin failures++; $display("FAIL rst_ready: got %b, need 000", tx_ready); end
    checks++;
    if (busy !== 3'b000) begin failures++; $display("FAIL rst_busy: got %b, need 000", busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 3'b000) begin failures++; $display("FAIL rel_ready_early: got %b, need 000", tx_ready); end
    @(negedge clk);
    checks++;
    if (tx_ready !== 3'b111) begin failures++; $display("FAIL rel_ready: got %b, need 111", tx_ready); end
    checks++;
    if (busy !== 3'b000 || txd !== 3'b111) begin
      failures++;
      $display("FAIL rel_idle: busy=%b txd=%b, need busy=000 txd=111", busy, txd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    int acc;
    int waited;
    exp_q.delete();
    drive_byte(0, 8'h55, 1'b0, acc);
    @(negedge clk);
    checks++;
    if (txd[0] !== 1'b1) begin failures++; $display("FAIL slow_latency_early: txd=%b, need 1", txd[0]); end
    checks++;
    if (tx_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL slow_held: tx_ready=%b busy=%b, need 0 1", tx_ready[0], busy[0]);
    end
    recv_check(0, 1'b1, "slow_55", waited);
    checks++;
    if (waited != 0) begin failures++; $display("FAIL slow_latency: start %0d cycles late, need 0", waited); end
    check_idle(0, 20, "slow");
  endtask

  task automatic test_back_to_back();
    int acc;
    int waited;
    exp_q.delete();
    fork
      begin
        drive_byte(1, 8'hA3, 1'b0, acc);
        drive_byte(1, 8'h0F, 1'b0, acc);
        // holding register now full: this byte must not be taken
        tx_data[1]  = 8'h99;
        tx_valid[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tx_valid[1] = 1'b0;
      end
      begin
        recv_check(1, 1'b1, "b2b_a3", waited);
        recv_check(1, 1'b0, "b2b_0f", waited);
      end
    join
    check_idle(1, 15 * CPB1, "b2b");
  endtask

  task automatic test_valid_held();
    int acc;
    int waited;
    exp_q.delete();
    fork
      begin
        drive_byte(1, 8'hFF, 1'b1, acc);
        drive_byte(1, 8'h00, 1'b1, acc);
        drive_byte(1, 8'h81, 1'b0, acc);
      end
      begin
        recv_check(1, 1'b1, "held_ff", waited);
        recv_check(1, 1'b0, "held_00", waited);
        recv_check(1, 1'b0, "held_81", waited);
      end
    join
    check_idle(1, 15 * CPB1, "held");
  endtask

  task automatic test_transfer_collision();
    int acc;
    int acc_a;
    int waited;
    exp_q.delete();
    fork
      begin
        drive_byte(1, 8'h3C, 1'b0, acc_a);
        drive_byte(1, 8'hC5, 1'b0, acc);
        // last cycle of the 3C stop bit: next edge moves C5 into the shifter
        for (int k = 0; k < 200 && cyc != acc_a + FRAME_BITS * CPB1; k++) begin
          @(posedge clk);
          #1;
        end
        checks++;
        if (cyc != acc_a + FRAME_BITS * CPB1 || tx_ready[1] !== 1'b0) begin
          failures++;
          $display("FAIL coll_ready: cyc=%0d tx_ready=%b, need cyc=%0d tx_ready=0",
                   cyc, tx_ready[1], acc_a + FRAME_BITS * CPB1);
        end
        drive_byte(1, 8'h5A, 1'b0, acc);
      end
      begin
        recv_check(1, 1'b1, "coll_3c", waited);
        recv_check(1, 1'b0, "coll_c5", waited);
        recv_check(1, 1'b0, "coll_5a", waited);
      end
    join
    check_idle(1, 15 * CPB1, "coll");
  endtask

  task automatic test_reset_abort();
    int acc;
    int start_cyc;
    int target;
    exp_q.delete();
    drive_byte(2, 8'hB6, 1'b0, acc);
    start_cyc = acc + 1;
    drive_byte(2, 8'h4D, 1'b0, acc);
    // cycle 17 of data bit 3 (frame bit 4)
    target = start_cyc + 4 * CPB2 + 17;
    for (int k = 0; k < 400 && cyc != target; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (txd[2] !== 1'b0 || busy[2] !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: txd=%b busy=%b, need 0 1", txd[2], busy[2]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (txd[2] !== 1'b1) begin failures++; $display("FAIL abort_txd: got %b, need 1", txd[2]); end
    checks++;
    if (busy[2] !== 1'b0 || tx_ready[2] !== 1'b0) begin
      failures++;
      $display("FAIL abort_flags: busy=%b tx_ready=%b, need 0 0", busy[2], tx_ready[2]);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready[2] !== 1'b0) begin failures++; $display("FAIL abort_ready_early: got %b, need 0", tx_ready[2]); end
    @(posedge clk);
    #1;
    checks++;
    if (tx_ready[2] !== 1'b1 || busy[2] !== 1'b0) begin
      failures++;
      $display("FAIL abort_release: tx_ready=%b busy=%b, need 1 0", tx_ready[2], busy[2]);
    end
    check_idle(2, 30 * CPB2, "abort");
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_valid_held();
    test_transfer_collision();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
